// File: rtl/wb_pkg.sv
// Shared types and limits for the Wishbone memory slave.
package wb_pkg;
    typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_RESP} wb_state_t;
    localparam int WB_MAX_WAIT = 15;
endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone-classic bus bundle between an interconnect master and the memory slave.
interface wb_mem_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  strb;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;
    logic                  err;

    modport master (output cyc, strb, we, addr, sel, wdata, input rdata, ack, err);
    modport slave  (input cyc, strb, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/wb_byte_ram.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
module wb_byte_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] we_lane,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              addr_ok;

    always_comb begin
        addr_ok = 32'(addr) < 32'(DEPTH);
        rdata_d = addr_ok ? mem[addr] : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_lane[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone-classic memory slave: request latch, wait-state counter, range check and
// a three-state IDLE/WAIT/RESP handshake in front of a byte-writable RAM.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    wb_mem_slave_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("wb_mem_slave: DATA_W must be a multiple of 8");
    end
    if (64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
        $error("wb_mem_slave: DEPTH exceeds the address space");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > WB_MAX_WAIT) begin : g_bad_wait
        $error("wb_mem_slave: WAIT_STATES out of range");
    end

    wb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LANES-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [LANES-1:0]  req_sel;
    logic [DATA_W-1:0] req_wdata;
    logic              in_range;
    logic              go_resp;
    logic [LANES-1:0]  ram_we_lane;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        // With zero wait states the access commits on the sampling edge, so the live bus is used.
        req_addr  = (state_q == WB_IDLE) ? bus.addr  : addr_q;
        req_we    = (state_q == WB_IDLE) ? bus.we    : we_q;
        req_sel   = (state_q == WB_IDLE) ? bus.sel   : sel_q;
        req_wdata = (state_q == WB_IDLE) ? bus.wdata : wdata_q;
        in_range  = 32'(req_addr) < 32'(DEPTH);

        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (bus.cyc && bus.strb) begin
                    addr_d  = bus.addr;
                    we_d    = bus.we;
                    sel_d   = bus.sel;
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    if (WAIT_STATES == 0) begin
                        state_d = WB_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WB_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                // Losing cyc abandons the access; strb alone is ignored once latched.
                if (!bus.cyc) begin
                    state_d = WB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = WB_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB_RESP: state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase

        ack_d       = go_resp && in_range;
        err_d       = go_resp && !in_range;
        ram_we_lane = (go_resp && req_we && in_range && !rst) ? req_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    wb_byte_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_lane (ram_we_lane),
        .addr    (req_addr),
        .wdata   (req_wdata),
        .rdata   (ram_rdata)
    );

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = (ack_q && !we_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: three instances with 0, 3 and 2 wait states share one driver.
module tb_wb_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, strb, we;
    logic [7:0]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dsel;
    logic        m_ack, m_err;
    logic [31:0] m_rdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    wb_mem_slave_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
    wb_mem_slave_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
    wb_mem_slave_if #(.ADDR_W(8), .DATA_W(32)) b2 ();

    assign b0.cyc = cyc && (dsel == 0);
    assign b1.cyc = cyc && (dsel == 1);
    assign b2.cyc = cyc && (dsel == 2);
    assign b0.strb = strb;  assign b1.strb = strb;  assign b2.strb = strb;
    assign b0.we = we;      assign b1.we = we;      assign b2.we = we;
    assign b0.addr = addr;  assign b1.addr = addr;  assign b2.addr = addr;
    assign b0.sel = sel;    assign b1.sel = sel;    assign b2.sel = sel;
    assign b0.wdata = wdata; assign b1.wdata = wdata; assign b2.wdata = wdata;

    wb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(b0.slave));
    wb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(b1.slave));
    wb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst(rst), .bus(b2.slave));

    always_comb begin
        m_ack = b0.ack;  m_err = b0.err;  m_rdata = b0.rdata;
        if (dsel == 1) begin m_ack = b1.ack; m_err = b1.err; m_rdata = b1.rdata; end
        if (dsel == 2) begin m_ack = b2.ack; m_err = b2.err; m_rdata = b2.rdata; end
    end

    // One bus access held until termination; returns what was seen, compares nothing.
    task automatic access(input int d, input logic w, input logic [7:0] a, input logic [3:0] s,
                          input logic [31:0] wd, output int lat, output logic got_ack,
                          output logic got_err, output logic [31:0] rd,
                          output logic [31:0] rd_before, output logic busy_after);
        dsel = d; cyc = 1'b1; strb = 1'b1; we = w; addr = a; sel = s; wdata = wd;
        lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0; rd_before = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (m_ack || m_err) begin
                lat = k; got_ack = m_ack; got_err = m_err; rd = m_rdata;
                break;
            end
            rd_before |= m_rdata;
        end
        cyc = 1'b0; strb = 1'b0;
        @(posedge clk); #1;
        busy_after = m_ack | m_err | (|m_rdata);
    endtask

    int lat; logic ga, ge, busy; logic [31:0] rd, rdb;

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; strb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0; dsel = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b0.ack, b0.err, b1.ack, b1.err, b2.ack, b2.err} !== 6'b0 || (b0.rdata | b1.rdata | b2.rdata) !== 32'h0) begin
            failures++; $display("FAIL reset_outputs got ack/err=%b%b%b%b%b%b rdata_or=%h exp=0",
                b0.ack, b0.err, b1.ack, b1.err, b2.ack, b2.err, b0.rdata | b1.rdata | b2.rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        access(1, 1'b1, 8'h10, 4'hF, 32'h0000_0000, lat, ga, ge, rd, rdb, busy);
        dsel = 1; cyc = 1'b1; strb = 1'b1; we = 1'b1; addr = 8'h10; sel = 4'hF; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; strb = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (m_ack !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0) begin
                failures++; $display("FAIL rst_mid_outputs got ack=%b err=%b rdata=%h exp 0/0/0", m_ack, m_err, m_rdata);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen |= m_ack | m_err;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ack got=%b exp=0", seen); end
        access(1, 1'b0, 8'h10, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b1 || rd !== 32'h0000_0000) begin
            failures++; $display("FAIL rst_mid_readback got ack=%b rdata=%h exp ack=1 rdata=00000000", ga, rd);
        end
    endtask

    task automatic test_full_rw();
        access(0, 1'b1, 8'h05, 4'hF, 32'hA5A5_1234, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (lat !== 1 || ga !== 1'b1 || ge !== 1'b0) begin
            failures++; $display("FAIL ws0_write got lat=%0d ack=%b err=%b exp lat=1 ack=1 err=0", lat, ga, ge);
        end
        access(0, 1'b0, 8'h05, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (lat !== 1 || ga !== 1'b1 || rd !== 32'hA5A5_1234) begin
            failures++; $display("FAIL ws0_read got lat=%0d ack=%b rdata=%h exp lat=1 ack=1 rdata=a5a51234", lat, ga, rd);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ws0_rdata_masked got busy=%b exp=0", busy); end
    endtask

    task automatic test_byte_lanes();
        access(0, 1'b1, 8'h07, 4'hF, 32'h1122_3344, lat, ga, ge, rd, rdb, busy);
        access(0, 1'b1, 8'h07, 4'b0101, 32'hAABB_CCDD, lat, ga, ge, rd, rdb, busy);
        access(0, 1'b0, 8'h07, 4'b0000, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b1 || rd !== 32'h11BB_33DD) begin
            failures++; $display("FAIL byte_lanes got ack=%b rdata=%h exp ack=1 rdata=11bb33dd", ga, rd);
        end
    endtask

    task automatic test_wait_states();
        access(1, 1'b1, 8'h33, 4'hF, 32'h5566_7788, lat, ga, ge, rd, rdb, busy);
        access(1, 1'b0, 8'h33, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (lat !== 4 || ga !== 1'b1 || rd !== 32'h5566_7788) begin
            failures++; $display("FAIL ws3_read got lat=%0d ack=%b rdata=%h exp lat=4 ack=1 rdata=55667788", lat, ga, rd);
        end
        checks++;
        if (rdb !== 32'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL ws3_pulse got rdata_before=%h after=%b exp 0/0", rdb, busy);
        end
    endtask

    task automatic test_out_of_range();
        access(0, 1'b1, 8'd200, 4'hF, 32'hFFFF_FFFF, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (lat !== 1 || ga !== 1'b0 || ge !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL oor_write got lat=%0d ack=%b err=%b after=%b exp lat=1 ack=0 err=1 after=0", lat, ga, ge, busy);
        end
        access(0, 1'b0, 8'd200, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL oor_read got ack=%b err=%b rdata=%h exp ack=0 err=1 rdata=0", ga, ge, rd);
        end
        access(0, 1'b1, 8'd199, 4'hF, 32'hCAFE_F00D, lat, ga, ge, rd, rdb, busy);
        access(0, 1'b0, 8'd199, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL last_word got ack=%b err=%b rdata=%h exp ack=1 err=0 rdata=cafef00d", ga, ge, rd);
        end
        access(0, 1'b0, 8'd255, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1) begin failures++; $display("FAIL oor_255 got ack=%b err=%b exp ack=0 err=1", ga, ge); end
        access(0, 1'b0, 8'h05, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (rd !== 32'hA5A5_1234) begin failures++; $display("FAIL oor_keep_05 got=%h exp=a5a51234", rd); end
        access(0, 1'b0, 8'h07, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL oor_keep_07 got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_strb_no_cyc();
        logic seen;
        seen = 1'b0;
        dsel = 0; cyc = 1'b0; strb = 1'b1; we = 1'b1; addr = 8'h05; sel = 4'hF; wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            seen |= m_ack | m_err;
        end
        strb = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL strb_no_cyc got=%b exp=0", seen); end
        access(0, 1'b0, 8'h05, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (rd !== 32'hA5A5_1234) begin failures++; $display("FAIL strb_no_cyc_data got=%h exp=a5a51234", rd); end
    endtask

    task automatic test_abort();
        logic seen;
        access(2, 1'b1, 8'h20, 4'hF, 32'h1234_5678, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (lat !== 3 || ga !== 1'b1) begin failures++; $display("FAIL ws2_write got lat=%0d ack=%b exp lat=3 ack=1", lat, ga); end
        dsel = 2; cyc = 1'b1; strb = 1'b1; we = 1'b1; addr = 8'h20; sel = 4'hF; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        cyc = 1'b0; strb = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen |= m_ack | m_err;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_resp got=%b exp=0", seen); end
        access(2, 1'b0, 8'h20, 4'hF, 32'h0, lat, ga, ge, rd, rdb, busy);
        checks++;
        if (ga !== 1'b1 || rd !== 32'h1234_5678) begin
            failures++; $display("FAIL abort_keep got ack=%b rdata=%h exp ack=1 rdata=12345678", ga, rd);
        end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        logic bad_data;
        bad_data = 1'b0;
        dsel = 2; cyc = 1'b1; strb = 1'b1; we = 1'b0; addr = 8'h20; sel = 4'hF;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (m_ack) begin
                pos.push_back(k);
                if (m_rdata !== 32'h1234_5678) bad_data = 1'b1;
            end
        end
        cyc = 1'b0; strb = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pos.size() != 3 || pos[0] != 3 || pos[1] != 7 || pos[2] != 11) begin
            failures++; $display("FAIL b2b_period got count=%0d first=%0d exp count=3 at 3,7,11",
                pos.size(), (pos.size() > 0) ? pos[0] : -1);
        end
        checks++;
        if (bad_data !== 1'b0) begin failures++; $display("FAIL b2b_data got bad=%b exp=0", bad_data); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_full_rw();
        test_byte_lanes();
        test_wait_states();
        test_out_of_range();
        test_strb_no_cyc();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
